// File: rtl/neo_sound_mailbox.sv
// neo_sound_mailbox: 68K <-> Z80 sound command/reply mailbox.
// All strobes are sampled on CLK and edge-detected against a one-cycle history.
// Optional build macro SOUND_CMD_FIFO_EN replaces the single command latch
// with a 4-entry command FIFO and adds the sticky CMD_OVF output.
module neo_sound_mailbox #(
  parameter logic [7:0] RESET_REPLY    = 8'h00,
  parameter logic       NMI_EN_DEFAULT = 1'b0
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] M68K_DATA,
  input  logic       nSDW,
  input  logic       nSDRD68,
  input  logic [7:0] SDD_IN,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic       nSDZ80CLR,
  input  logic       nNMI_SET,
  input  logic       nNMI_RESET,
  output logic [7:0] CMD_OUT,
  output logic [7:0] REPLY_OUT,
  output logic       CMD_PENDING,
  output logic       REPLY_READ,
  output logic       nZ80NMI
`ifdef SOUND_CMD_FIFO_EN
  ,
  output logic       CMD_OVF
`endif
);

  // 'sampled' blocks falling events on the first edge after reset, so a strobe
  // that is already low when reset releases never looks like a fresh edge.
  logic sampled;
  logic prev_sdw, prev_rd68, prev_z80r, prev_z80w, prev_clr, prev_nset, prev_nrst;
  logic sdw_fall, rd68_rise, z80r_rise, z80w_fall, clr_fall, nset_fall, nrst_fall;
  logic pend_next, nmi_en, nmi_en_next;

  // Strobe history registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sampled   <= 1'b0;
      prev_sdw  <= 1'b1;
      prev_rd68 <= 1'b1;
      prev_z80r <= 1'b1;
      prev_z80w <= 1'b1;
      prev_clr  <= 1'b1;
      prev_nset <= 1'b1;
      prev_nrst <= 1'b1;
    end else begin
      sampled   <= 1'b1;
      prev_sdw  <= nSDW;
      prev_rd68 <= nSDRD68;
      prev_z80r <= nSDZ80R;
      prev_z80w <= nSDZ80W;
      prev_clr  <= nSDZ80CLR;
      prev_nset <= nNMI_SET;
      prev_nrst <= nNMI_RESET;
    end
  end

  assign sdw_fall  = sampled & prev_sdw  & ~nSDW;
  assign z80w_fall = sampled & prev_z80w & ~nSDZ80W;
  assign clr_fall  = sampled & prev_clr  & ~nSDZ80CLR;
  assign nset_fall = sampled & prev_nset & ~nNMI_SET;
  assign nrst_fall = sampled & prev_nrst & ~nNMI_RESET;
  assign z80r_rise = ~prev_z80r & nSDZ80R;
  assign rd68_rise = ~prev_rd68 & nSDRD68;

`ifdef SOUND_CMD_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, push_addr;
  logic [2:0] count, count_d;
  logic       ovf, ovf_d, push_en;

  // FIFO next state: flush or pop first, then the push sees the freed slot.
  always_comb begin
    wr_ptr_d  = wr_ptr;
    rd_ptr_d  = rd_ptr;
    count_d   = count;
    ovf_d     = ovf;
    push_en   = 1'b0;
    if (clr_fall) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
      ovf_d    = 1'b0;
    end else if (z80r_rise && count != 3'd0) begin
      rd_ptr_d = rd_ptr + 2'd1;
      count_d  = count - 3'd1;
    end
    push_addr = wr_ptr_d;
    if (sdw_fall) begin
      if (count_d == 3'd4) begin
        ovf_d = 1'b1;
      end else begin
        push_en  = 1'b1;
        wr_ptr_d = wr_ptr_d + 2'd1;
        count_d  = count_d + 3'd1;
      end
    end
  end

  // FIFO pointer/count/overflow registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
      ovf    <= ovf_d;
    end
  end

  // FIFO storage; empty slots are never shown because CMD_OUT masks on count.
  always_ff @(posedge CLK) begin
    if (push_en) fifo_mem[push_addr] <= M68K_DATA;
  end

  assign pend_next   = (count_d != 3'd0);
  assign CMD_OUT     = (count == 3'd0) ? 8'h00 : fifo_mem[rd_ptr];
  assign CMD_PENDING = (count != 3'd0);
  assign CMD_OVF     = ovf;
`else
  logic [7:0] cmd_q, cmd_d;
  logic       pend_q;

  // Command latch next state: a new write always beats a clear or read-complete.
  always_comb begin
    cmd_d     = cmd_q;
    pend_next = pend_q;
    if (sdw_fall) begin
      cmd_d     = M68K_DATA;
      pend_next = 1'b1;
    end else if (clr_fall) begin
      cmd_d     = 8'h00;
      pend_next = 1'b0;
    end else if (z80r_rise) begin
      pend_next = 1'b0;
    end
  end

  // Command latch registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cmd_q  <= 8'h00;
      pend_q <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      pend_q <= pend_next;
    end
  end

  assign CMD_OUT     = cmd_q;
  assign CMD_PENDING = pend_q;
`endif

  // Disable wins when both NMI port strobes fall together.
  assign nmi_en_next = nrst_fall ? 1'b0 : (nset_fall ? 1'b1 : nmi_en);

  // NMI enable and the registered NMI output, driven from next-state values.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      nmi_en  <= NMI_EN_DEFAULT;
      nZ80NMI <= 1'b1;
    end else begin
      nmi_en  <= nmi_en_next;
      nZ80NMI <= ~(pend_next & nmi_en_next);
    end
  end

  // Reply path: a Z80 reply write beats a simultaneous 68K read completion.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      REPLY_OUT  <= RESET_REPLY;
      REPLY_READ <= 1'b1;
    end else if (z80w_fall) begin
      REPLY_OUT  <= SDD_IN;
      REPLY_READ <= 1'b0;
    end else if (rd68_rise) begin
      REPLY_READ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neo_sound_mailbox.sv
// Self-checking bench for neo_sound_mailbox: directed steps, expected state
// pushed to a scoreboard queue at stimulus time and popped after the edge.
module tb_neo_sound_mailbox;

`ifdef SOUND_CMD_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic [7:0] M68K_DATA = 8'h00;
  logic       nSDW = 1'b1, nSDRD68 = 1'b1;
  logic [7:0] SDD_IN = 8'h00;
  logic       nSDZ80R = 1'b1, nSDZ80W = 1'b1, nSDZ80CLR = 1'b1;
  logic       nNMI_SET = 1'b1, nNMI_RESET = 1'b1;
  logic [7:0] CMD_OUT, REPLY_OUT;
  logic       CMD_PENDING, REPLY_READ, nZ80NMI;
`ifdef SOUND_CMD_FIFO_EN
  logic       CMD_OVF;
`endif

  neo_sound_mailbox dut (
    .CLK(CLK), .nRESET(nRESET), .M68K_DATA(M68K_DATA), .nSDW(nSDW),
    .nSDRD68(nSDRD68), .SDD_IN(SDD_IN), .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W),
    .nSDZ80CLR(nSDZ80CLR), .nNMI_SET(nNMI_SET), .nNMI_RESET(nNMI_RESET),
    .CMD_OUT(CMD_OUT), .REPLY_OUT(REPLY_OUT), .CMD_PENDING(CMD_PENDING),
    .REPLY_READ(REPLY_READ), .nZ80NMI(nZ80NMI)
`ifdef SOUND_CMD_FIFO_EN
    , .CMD_OVF(CMD_OVF)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] reply;
    logic       pend;
    logic       rd;
    logic       nmi;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input logic [7:0] cmd, input logic [7:0] reply,
                              input logic pend, input logic rd, input logic nmi);
    exp_t e;
    e.cmd = cmd; e.reply = reply; e.pend = pend; e.rd = rd; e.nmi = nmi;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".cmd"},   CMD_OUT,             e.cmd);
      chk({tag, ".reply"}, REPLY_OUT,           e.reply);
      chk({tag, ".pend"},  {7'd0, CMD_PENDING}, {7'd0, e.pend});
      chk({tag, ".rd"},    {7'd0, REPLY_READ},  {7'd0, e.rd});
      chk({tag, ".nmi"},   {7'd0, nZ80NMI},     {7'd0, e.nmi});
    end
  endtask

  initial begin
    int waited;
    tick(); tick();
    expect_state(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check_sb("reset");
    nRESET = 1'b1;
    tick();

    // Command write with NMI disabled.
    M68K_DATA = 8'h5A; nSDW = 1'b0;
    expect_state(8'h5A, 8'h00, 1'b1, 1'b1, 1'b1);
    tick(); check_sb("cmd_write");
    nSDW = 1'b1; tick();

    // Enable NMI while pending; bounded wait for nZ80NMI low.
    nNMI_SET = 1'b0; tick(); nNMI_SET = 1'b1;
    waited = 0;
    while (nZ80NMI !== 1'b0 && waited < 2) begin tick(); waited++; end
    chk("nmi_within_2", {7'd0, nZ80NMI}, 8'h00);
    expect_state(8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
    check_sb("nmi_on");

    // Three-cycle Z80 read; data held throughout, pending drops after rise.
    nSDZ80R = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_state(8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
      tick(); check_sb("z80_read_hold");
    end
    nSDZ80R = 1'b1;
    expect_state(FIFO_MODE ? 8'h00 : 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1);
    tick(); check_sb("z80_read_done");

    // Reply write then 68K reply read.
    SDD_IN = 8'hC3; nSDZ80W = 1'b0;
    expect_state(CMD_OUT, 8'hC3, 1'b0, 1'b0, 1'b1);
    sb[sb.size()-1].cmd = FIFO_MODE ? 8'h00 : 8'h5A;
    tick(); check_sb("reply_write");
    nSDZ80W = 1'b1; tick();
    nSDRD68 = 1'b0; tick();
    nSDRD68 = 1'b1;
    expect_state(FIFO_MODE ? 8'h00 : 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b1);
    tick(); check_sb("reply_read");

    // Write coincides with read-complete: write wins.
    nSDZ80R = 1'b0; tick(); tick();
    M68K_DATA = 8'h11; nSDW = 1'b0; nSDZ80R = 1'b1;
    expect_state(8'h11, 8'hC3, 1'b1, 1'b1, 1'b0);
    tick(); check_sb("write_vs_read");
    nSDW = 1'b1; tick();

    // Write coincides with clear: write wins.
    M68K_DATA = 8'h22; nSDW = 1'b0; nSDZ80CLR = 1'b0;
    expect_state(8'h22, 8'hC3, 1'b1, 1'b1, 1'b0);
    tick(); check_sb("write_vs_clr");
    nSDW = 1'b1; nSDZ80CLR = 1'b1; tick();

    // Clear alone.
    nSDZ80CLR = 1'b0;
    expect_state(8'h00, 8'hC3, 1'b0, 1'b1, 1'b1);
    tick(); check_sb("clear");
    nSDZ80CLR = 1'b1; tick();

    // Reply write coincides with 68K read-complete: write wins.
    nSDRD68 = 1'b0; tick();
    SDD_IN = 8'h7E; nSDZ80W = 1'b0; nSDRD68 = 1'b1;
    expect_state(8'h00, 8'h7E, 1'b0, 1'b0, 1'b1);
    tick(); check_sb("reply_vs_read");
    nSDZ80W = 1'b1; tick();

    // Both NMI strobes together: disable wins, so a new command raises no NMI.
    nNMI_SET = 1'b0; nNMI_RESET = 1'b0; tick();
    nNMI_SET = 1'b1; nNMI_RESET = 1'b1; tick();
    M68K_DATA = 8'h33; nSDW = 1'b0;
    expect_state(8'h33, 8'h7E, 1'b1, 1'b0, 1'b1);
    tick(); check_sb("nmi_both");

    // Held-low write: one event only, later data ignored.
    M68K_DATA = 8'h44;
    for (int i = 0; i < 4; i++) tick();
    expect_state(8'h33, 8'h7E, 1'b1, 1'b0, 1'b1);
    check_sb("held_low");

    // Reset mid-strobe, release with nSDW still low.
    nRESET = 1'b0; #1;
    expect_state(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check_sb("async_reset");
    tick();
    M68K_DATA = 8'h55; nRESET = 1'b1;
    tick(); tick();
    expect_state(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check_sb("no_capture_after_reset");
    nSDW = 1'b1; tick();
    nSDW = 1'b0;
    expect_state(8'h55, 8'h00, 1'b1, 1'b1, 1'b1);
    tick(); check_sb("recapture");
    nSDW = 1'b1; tick();

`ifdef SOUND_CMD_FIFO_EN
    nSDZ80CLR = 1'b0; tick(); nSDZ80CLR = 1'b1; tick();
    for (int i = 1; i <= 5; i++) begin
      M68K_DATA = 8'(i); nSDW = 1'b0; tick();
      nSDW = 1'b1; tick();
    end
    chk("fifo_ovf", {7'd0, CMD_OVF}, 8'h01);
    chk("fifo_head", CMD_OUT, 8'h01);
    for (int i = 2; i <= 4; i++) begin
      nSDZ80R = 1'b0; tick(); nSDZ80R = 1'b1; tick();
      chk("fifo_pop", CMD_OUT, 8'(i));
    end
    nSDZ80R = 1'b0; tick(); nSDZ80R = 1'b1; tick();
    chk("fifo_empty_pend", {7'd0, CMD_PENDING}, 8'h00);
    chk("fifo_empty_cmd", CMD_OUT, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
